// File: rtl/tpu_pkg.sv
// Shared constants for the 2x2 systolic MMU operand path: widths, element
// addresses in the operand buffer, feed schedule length and lane-valid patterns.
package tpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SCHED_LEN = 3;
  localparam int unsigned N_ELEM    = 8;
  localparam int unsigned ADDR_W    = 3;

  // Row-major A then B
  localparam logic [ADDR_W-1:0] ADDR_A00 = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_A01 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_A10 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_A11 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_B00 = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_B01 = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_B10 = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_B11 = 3'd7;

  // Bit order {b_top1, b_top0, a_left1, a_left0}
  localparam logic [3:0] LV_NONE = 4'b0000;
  localparam logic [3:0] LV_C0   = 4'b0101;
  localparam logic [3:0] LV_C1   = 4'b1111;
  localparam logic [3:0] LV_C2   = 4'b1010;

endpackage

// File: rtl/skew_schedule.sv
// Combinational diagonal-skew selector: maps a compute-phase cycle onto the
// four MMU edge lanes, with matching lane-valid and accumulator-clear.
module skew_schedule
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = tpu_pkg::DATA_W
) (
  input  logic [ADDR_W-1:0]             feed_cycle,
  input  logic [N_ELEM-1:0][DATA_W-1:0] elem,
  output logic [DATA_W-1:0]             a_left0,
  output logic [DATA_W-1:0]             a_left1,
  output logic [DATA_W-1:0]             b_top0,
  output logic [DATA_W-1:0]             b_top1,
  output logic [3:0]                    lane_valid,
  output logic                          pe_clear
);

  always_comb begin
    a_left0    = '0;
    a_left1    = '0;
    b_top0     = '0;
    b_top1     = '0;
    lane_valid = LV_NONE;
    pe_clear   = 1'b0;
    case (feed_cycle)
      3'd0: begin
        a_left0    = elem[ADDR_A00];
        b_top0     = elem[ADDR_B00];
        lane_valid = LV_C0;
        pe_clear   = 1'b1;
      end
      3'd1: begin
        a_left0    = elem[ADDR_A01];
        a_left1    = elem[ADDR_A10];
        b_top0     = elem[ADDR_B10];
        b_top1     = elem[ADDR_B01];
        lane_valid = LV_C1;
      end
      3'd2: begin
        a_left1    = elem[ADDR_A11];
        b_top1     = elem[ADDR_B11];
        lane_valid = LV_C2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmu_operand_feeder.sv
// Operand buffer for the 2x2 MMU: captures 8 host bytes from the sequencer and
// replays them skewed onto the array edges while feeding is enabled.
module mmu_operand_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W    = tpu_pkg::DATA_W,
  parameter int unsigned SCHED_LEN = tpu_pkg::SCHED_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              feed_en,
  input  logic [2:0]        feed_cycle,
  output logic [DATA_W-1:0] a_left0,
  output logic [DATA_W-1:0] a_left1,
  output logic [DATA_W-1:0] b_top0,
  output logic [DATA_W-1:0] b_top1,
  output logic [3:0]        lane_valid,
  output logic              pe_clear,
  output logic              buf_full,
  output logic              err_sticky
);

  logic [N_ELEM-1:0][DATA_W-1:0] mem;
  logic [N_ELEM-1:0]             loaded_mask;

  logic [DATA_W-1:0] s_a0, s_a1, s_b0, s_b1;
  logic [3:0]        s_valid;
  logic              s_clear;

  logic do_load, bad_load, bad_start, last_beat;

  assign buf_full  = &loaded_mask;
  assign do_load   = load_en && !feed_en;
  assign bad_load  = load_en && feed_en;
  assign bad_start = feed_en && (feed_cycle == 3'd0) && !buf_full;
  assign last_beat = feed_en && (feed_cycle == 3'(SCHED_LEN - 1));

  skew_schedule #(.DATA_W(DATA_W)) u_sched (
    .feed_cycle (feed_cycle),
    .elem       (mem),
    .a_left0    (s_a0),
    .a_left1    (s_a1),
    .b_top0     (s_b0),
    .b_top1     (s_b1),
    .lane_valid (s_valid),
    .pe_clear   (s_clear)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem         <= '0;
      loaded_mask <= '0;
    end else begin
      if (do_load) mem[load_addr] <= load_data;
      // Clear has priority; a load coinciding with feed is dropped anyway
      if (last_beat)    loaded_mask            <= '0;
      else if (do_load) loaded_mask[load_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_left0    <= '0;
      a_left1    <= '0;
      b_top0     <= '0;
      b_top1     <= '0;
      lane_valid <= '0;
      pe_clear   <= 1'b0;
    end else if (feed_en) begin
      a_left0    <= s_a0;
      a_left1    <= s_a1;
      b_top0     <= s_b0;
      b_top1     <= s_b1;
      lane_valid <= s_valid;
      pe_clear   <= s_clear;
    end else begin
      a_left0    <= '0;
      a_left1    <= '0;
      b_top0     <= '0;
      b_top1     <= '0;
      lane_valid <= '0;
      pe_clear   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_sticky <= 1'b0;
    else if (bad_load || bad_start)   err_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_mmu_operand_feeder.sv
// Scoreboard bench for mmu_operand_feeder: stimulus queues expected feed beats,
// a monitor compares them one cycle after each sampled feed_en edge.
module tb_mmu_operand_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [2:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       feed_en = 1'b0;
  logic [2:0] feed_cycle = '0;
  logic [7:0] a_left0, a_left1, b_top0, b_top1;
  logic [3:0] lane_valid;
  logic       pe_clear, buf_full, err_sticky;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic [7:0] a0, a1, b0, b1;
    logic [3:0] v;
    logic       c;
  } exp_t;

  exp_t q[$];

  mmu_operand_feeder #(.DATA_W(8), .SCHED_LEN(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .feed_en    (feed_en),
    .feed_cycle (feed_cycle),
    .a_left0    (a_left0),
    .a_left1    (a_left1),
    .b_top0     (b_top0),
    .b_top1     (b_top1),
    .lane_valid (lane_valid),
    .pe_clear   (pe_clear),
    .buf_full   (buf_full),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: every edge that sampled feed_en=1 out of reset owes one beat
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (feed_en && rst_n) begin
        #1;
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got a beat, expected none queued");
        end else begin
          e = q.pop_front();
          check({e.name, ".a_left0"},    32'(a_left0),    32'(e.a0));
          check({e.name, ".a_left1"},    32'(a_left1),    32'(e.a1));
          check({e.name, ".b_top0"},     32'(b_top0),     32'(e.b0));
          check({e.name, ".b_top1"},     32'(b_top1),     32'(e.b1));
          check({e.name, ".lane_valid"}, 32'(lane_valid), 32'(e.v));
          check({e.name, ".pe_clear"},   32'(pe_clear),   32'(e.c));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    load_en = 1'b0;
    feed_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    load_en = 1'b1;
    load_addr = addr;
    load_data = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic feed(input logic [2:0] cyc, input exp_t e);
    q.push_back(e);
    feed_en = 1'b1;
    feed_cycle = cyc;
    @(negedge clk);
  endtask

  task automatic idle();
    feed_en = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
  endtask

  exp_t zero_row;

  initial begin
    zero_row = '{"zero", 8'h0, 8'h0, 8'h0, 8'h0, 4'b0000, 1'b0};
    @(negedge clk);
    check("reset.lane_valid", 32'(lane_valid), 0);
    check("reset.a_left0",    32'(a_left0), 0);
    check("reset.pe_clear",   32'(pe_clear), 0);
    check("reset.buf_full",   32'(buf_full), 0);
    check("reset.err_sticky", 32'(err_sticky), 0);
    do_reset();

    // Scenario 1: load 1..8
    for (int i = 0; i < 8; i++) begin
      load(3'(i), 8'(i + 1));
      if (i == 6) check("s1.buf_full_at7", 32'(buf_full), 0);
    end
    check("s1.buf_full", 32'(buf_full), 1);
    check("s1.err_sticky", 32'(err_sticky), 0);

    // Scenario 2: skewed replay
    feed(3'd0, '{"s2.c0", 8'd1, 8'd0, 8'd5, 8'd0, 4'b0101, 1'b1});
    feed(3'd1, '{"s2.c1", 8'd2, 8'd3, 8'd7, 8'd6, 4'b1111, 1'b0});
    check("s2.buf_full_before_c2", 32'(buf_full), 1);
    feed(3'd2, '{"s2.c2", 8'd0, 8'd4, 8'd0, 8'd8, 4'b1010, 1'b0});
    check("s2.buf_full_after_c2", 32'(buf_full), 0);
    feed(3'd3, '{"s2.c3", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0});
    feed(3'd4, '{"s2.c4", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0});
    feed(3'd5, '{"s2.c5", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0});
    feed(3'd7, '{"s2.c7", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0});
    check("s2.err_sticky", 32'(err_sticky), 0);
    feed(3'd1, '{"s2.c1_again", 8'd2, 8'd3, 8'd7, 8'd6, 4'b1111, 1'b0});
    idle();
    check("s2.idle_valid", 32'(lane_valid), 0);
    check("s2.idle_a_left0", 32'(a_left0), 0);

    // Scenario 3: load during feed is dropped and flagged
    load_en = 1'b1;
    load_addr = 3'd2;
    load_data = 8'hFF;
    feed(3'd1, '{"s3.c1_load", 8'd2, 8'd3, 8'd7, 8'd6, 4'b1111, 1'b0});
    load_en = 1'b0;
    feed(3'd1, '{"s3.c1_after", 8'd2, 8'd3, 8'd7, 8'd6, 4'b1111, 1'b0});
    idle();
    check("s3.err_sticky", 32'(err_sticky), 1);
    check("s3.buf_full", 32'(buf_full), 0);

    // Scenario 4: start with a partial buffer
    do_reset();
    check("s4.err_after_reset", 32'(err_sticky), 0);
    for (int i = 0; i < 7; i++) load(3'(i), 8'(i + 1));
    check("s4.buf_full", 32'(buf_full), 0);
    feed(3'd0, '{"s4.c0", 8'd1, 8'd0, 8'd5, 8'd0, 4'b0101, 1'b1});
    idle();
    check("s4.err_sticky", 32'(err_sticky), 1);

    // Scenario 5: asynchronous reset mid-feed
    do_reset();
    for (int i = 0; i < 8; i++) load(3'(i), 8'(i + 1));
    feed(3'd0, '{"s5.c0", 8'd1, 8'd0, 8'd5, 8'd0, 4'b0101, 1'b1});
    feed(3'd1, '{"s5.c1", 8'd2, 8'd3, 8'd7, 8'd6, 4'b1111, 1'b0});
    check("s5.pre_reset_valid", 32'(lane_valid), 32'hF);
    rst_n = 1'b0;
    #1;
    check("s5.rst_valid",   32'(lane_valid), 0);
    check("s5.rst_a_left0", 32'(a_left0), 0);
    check("s5.rst_b_top1",  32'(b_top1), 0);
    check("s5.rst_buf_full", 32'(buf_full), 0);
    feed_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5.buf_full_after", 32'(buf_full), 0);
    feed(3'd1, '{"s5.c1_lost", 8'd0, 8'd0, 8'd0, 8'd0, 4'b1111, 1'b0});
    idle();

    // Scenario 6: rewrite overwrites without error
    load(3'd4, 8'h11);
    load(3'd4, 8'h22);
    load(3'd0, 8'h01);
    load(3'd1, 8'h02);
    load(3'd2, 8'h03);
    load(3'd3, 8'h04);
    load(3'd5, 8'h06);
    load(3'd6, 8'h07);
    check("s6.buf_full_at7", 32'(buf_full), 0);
    load(3'd7, 8'h08);
    check("s6.buf_full", 32'(buf_full), 1);
    feed(3'd0, '{"s6.c0", 8'h01, 8'h00, 8'h22, 8'h00, 4'b0101, 1'b1});
    idle();
    check("s6.err_sticky", 32'(err_sticky), 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d beats pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
